// File: rtl/axi_lite_sram_lat.sv
// AXI4-Lite slave over an internal word-addressed SRAM.
// Read and write channels are independent FSMs, each with one transaction
// in flight and a parameterised wait before the response is presented.
// Out-of-range addresses complete normally but return DECERR.
module axi_lite_sram_lat #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1,
    localparam int               STRB_W    = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    output logic [1:0]        bresp,
    input  logic              bready
);

    localparam int         OFF_W       = $clog2(STRB_W);
    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_en;

    r_state_t          r_state, r_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] rd_addr_eff;
    logic [ADDR_W-1:0] rd_off;
    logic              rd_ok;
    logic [IDX_W-1:0]  rd_idx;
    logic              ar_hs;
    logic              r_enter;

    w_state_t          w_state, w_next;
    logic [3:0]        w_cnt;
    logic              have_aw, have_w;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [ADDR_W-1:0] wr_addr_eff;
    logic [DATA_W-1:0] wr_data_eff;
    logic [STRB_W-1:0] wr_strb_eff;
    logic [ADDR_W-1:0] wr_off;
    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic              aw_hs, w_hs;
    logic              w_enter;

    // Readies stay low in reset and for the first edge after release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign arready = ready_en && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign ar_hs   = arvalid && arready;

    assign awready = ready_en && (w_state == W_IDLE) && !have_aw;
    assign wready  = ready_en && (w_state == W_IDLE) && !have_w;
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // In IDLE the live address is used so a zero-latency read samples the right word
    assign rd_addr_eff = (r_state == R_IDLE) ? araddr : r_addr;
    assign rd_off      = rd_addr_eff - BASE_ADDR;
    assign rd_ok       = (rd_addr_eff >= BASE_ADDR) && ((rd_off >> OFF_W) < ADDR_W'(DEPTH));
    assign rd_idx      = rd_off[OFF_W +: IDX_W];

    // Held values win; otherwise the beat arriving this cycle is used
    assign wr_addr_eff = have_aw ? w_addr : awaddr;
    assign wr_data_eff = have_w  ? w_data : wdata;
    assign wr_strb_eff = have_w  ? w_strb : wstrb;
    assign wr_off      = wr_addr_eff - BASE_ADDR;
    assign wr_ok       = (wr_addr_eff >= BASE_ADDR) && ((wr_off >> OFF_W) < ADDR_W'(DEPTH));
    assign wr_idx      = wr_off[OFF_W +: IDX_W];

    assign r_enter = (r_next == R_RESP) && (r_state != R_RESP);
    assign w_enter = (w_next == W_RESP) && (w_state != W_RESP);

    // Read channel next-state logic
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
            R_WAIT: if (r_cnt == 4'd1) r_next = R_RESP;
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read channel state, wait counter and response registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_addr <= araddr;
                r_cnt  <= 4'(RD_LAT);
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_enter) begin
                rresp <= rd_ok ? RESP_OKAY : RESP_DECERR;
                rdata <= rd_ok ? mem[rd_idx] : '0;
            end
        end
    end

    // Write channel next-state logic: wait for both AW and W in any order
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if ((have_aw || aw_hs) && (have_w || w_hs))
                        w_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
            W_WAIT: if (w_cnt == 4'd1) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write channel state, capture flags, wait counter and response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) have_aw <= 1'b1;
            if (w_hs)  have_w  <= 1'b1;
            if (w_state == W_IDLE && w_next != W_IDLE) w_cnt <= 4'(WR_LAT);
            else if (w_state == W_WAIT)               w_cnt <= w_cnt - 4'd1;
            if (w_enter) bresp <= wr_ok ? RESP_OKAY : RESP_DECERR;
            if (w_state == W_RESP && bready) begin
                have_aw <= 1'b0;
                have_w  <= 1'b0;
            end
        end
    end

    // Write payload capture and byte-lane commit into the array
    always_ff @(posedge aclk) begin
        if (aw_hs) w_addr <= awaddr;
        if (w_hs) begin
            w_data <= wdata;
            w_strb <= wstrb;
        end
        if (w_enter && wr_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb_eff[i]) mem[wr_idx][8*i +: 8] <= wr_data_eff[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_lat.sv
// Directed bench for axi_lite_sram_lat with default parameters
// (DEPTH=1024, BASE_ADDR=0x8000_0000, RD_LAT=1, WR_LAT=1).
module tb_axi_lite_sram_lat;

    logic        aclk;
    logic        aresetn;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    int tests = 0;
    int fails = 0;

    axi_lite_sram_lat dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bresp   (bresp),
        .bready  (bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        int lat;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        check({tag, "_arready"}, arready, 1);
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin tick(); lat++; end
        check({tag, "_rlat"}, lat, 2);
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // mode 0: AW and W together, 1: AW before W, 2: W before AW
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int mode, output logic [1:0] resp);
        int n;
        int lat;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        n = 0;
        if (mode == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            while (!(awready && wready) && n < 50) begin tick(); n++; end
            check({tag, "_readies"}, {awready, wready}, 2'b11);
            tick();
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else if (mode == 1) begin
            awvalid = 1'b1;
            while (!awready && n < 50) begin tick(); n++; end
            check({tag, "_awready"}, awready, 1);
            tick();
            awvalid = 1'b0;
            check({tag, "_awready_drop"}, awready, 0);
            check({tag, "_wready_held"}, wready, 1);
            check({tag, "_bvalid_early"}, bvalid, 0);
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
        end else begin
            wvalid = 1'b1;
            while (!wready && n < 50) begin tick(); n++; end
            check({tag, "_wready"}, wready, 1);
            tick();
            wvalid = 1'b0;
            check({tag, "_wready_drop"}, wready, 0);
            check({tag, "_awready_held"}, awready, 1);
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end
        lat = 1;
        while (!bvalid && lat < 50) begin tick(); lat++; end
        check({tag, "_blat"}, lat, 2);
        resp   = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_bvalid_clr"}, bvalid, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  rsp;

        aresetn = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        // 1: reset values, ready release, first read latency
        tick();
        tick();
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", {rresp, bresp}, 4'b0000);
        check("rst_readies", {arready, awready, wready}, 3'b000);
        aresetn = 1'b1;
        #1;
        check("rel_readies_low", {arready, awready, wready}, 3'b000);
        tick();
        check("rel_readies_high", {arready, awready, wready}, 3'b111);
        araddr  = 32'h8000_0000;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t1_arready_drop", arready, 0);
        check("t1_rvalid_e1", rvalid, 0);
        tick();
        check("t1_rvalid_e2", rvalid, 1);
        check("t1_rresp", rresp, 2'b00);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("t1_rvalid_clr", rvalid, 0);
        check("t1_arready_back", arready, 1);

        // 2: AW-before-W partial strobe write over a known word
        do_write("t2_init", 32'h8000_0004, 32'h1111_1111, 4'hF, 0, rsp);
        check("t2_init_bresp", rsp, 2'b00);
        do_write("t2_aw1st", 32'h8000_0004, 32'hDEAD_BEEF, 4'b0101, 1, rsp);
        check("t2_bresp", rsp, 2'b00);
        do_read("t2_rd", 32'h8000_0004, d, rsp);
        check("t2_rdata", d, 32'h11AD_11EF);
        check("t2_rresp", rsp, 2'b00);
        do_write("t2_w1st", 32'h8000_0000, 32'hA5A5_0000, 4'hF, 2, rsp);
        check("t2_w1st_bresp", rsp, 2'b00);
        do_read("t2_rd0", 32'h8000_0000, d, rsp);
        check("t2_rd0_data", d, 32'hA5A5_0000);
        do_read("t2_rdoff", 32'h8000_0006, d, rsp);
        check("t2_rdoff_data", d, 32'h11AD_11EF);

        // 3: address decode boundaries
        do_write("t3_last", 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 0, rsp);
        check("t3_last_bresp", rsp, 2'b00);
        do_read("t3_lo", 32'h7FFF_FFFC, d, rsp);
        check("t3_lo_rresp", rsp, 2'b11);
        check("t3_lo_rdata", d, 32'h0);
        do_write("t3_hi", 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, rsp);
        check("t3_hi_bresp", rsp, 2'b11);
        do_read("t3_hi_rd", 32'h8000_1000, d, rsp);
        check("t3_hi_rresp", rsp, 2'b11);
        check("t3_hi_rdata", d, 32'h0);
        do_read("t3_w0", 32'h8000_0000, d, rsp);
        check("t3_w0_unchanged", d, 32'hA5A5_0000);
        do_read("t3_wlast", 32'h8000_0FFC, d, rsp);
        check("t3_wlast_data", d, 32'h0BAD_F00D);
        check("t3_wlast_rresp", rsp, 2'b00);

        // 4: R back-pressure holds the response and blocks the next AR
        araddr  = 32'h8000_0004;
        arvalid = 1'b1;
        tick();
        araddr = 32'h8000_0000;
        tick();
        check("t4_rvalid", rvalid, 1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_rvalid", rvalid, 1);
            check("t4_hold_rdata", rdata, 32'h11AD_11EF);
            check("t4_hold_rresp", rresp, 2'b00);
            check("t4_hold_arready", arready, 0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("t4_rvalid_clr", rvalid, 0);
        check("t4_arready_back", arready, 1);
        tick();
        arvalid = 1'b0;
        tick();
        check("t4_next_rvalid", rvalid, 1);
        check("t4_next_rdata", rdata, 32'hA5A5_0000);
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // 5: read sample and write commit on the same edge
        do_write("t5_init", 32'h8000_0008, 32'h2222_2222, 4'hF, 0, rsp);
        araddr = 32'h8000_0008; arvalid = 1'b1;
        awaddr = 32'h8000_0008; awvalid = 1'b1;
        wdata  = 32'h3333_3333; wstrb = 4'hF; wvalid = 1'b1;
        check("t5_readies", {arready, awready, wready}, 3'b111);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("t5_both_valid", {rvalid, bvalid}, 2'b11);
        check("t5_old_data", rdata, 32'h2222_2222);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read("t5_rd2", 32'h8000_0008, d, rsp);
        check("t5_new_data", d, 32'h3333_3333);

        // 6: reset in W_WAIT aborts the write
        do_write("t6_init", 32'h8000_000C, 32'h4444_4444, 4'hF, 0, rsp);
        awaddr = 32'h8000_000C; awvalid = 1'b1;
        wdata  = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t6_wait_bvalid", bvalid, 0);
        aresetn = 1'b0;
        #1;
        check("t6_rst_readies", {arready, awready, wready}, 3'b000);
        check("t6_rst_bvalid", bvalid, 0);
        tick();
        tick();
        check("t6_rst_bvalid2", bvalid, 0);
        aresetn = 1'b1;
        #1;
        check("t6_rel_readies_low", {arready, awready, wready}, 3'b000);
        tick();
        check("t6_rel_readies_high", {arready, awready, wready}, 3'b111);
        check("t6_rel_bvalid", bvalid, 0);
        do_read("t6_rd", 32'h8000_000C, d, rsp);
        check("t6_unchanged", d, 32'h4444_4444);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
